synapse_accumulator: RTL

//   Upstream stage of p_bit. Computes the local field I = h + sum_j J_j*m_j for one p-bit,

---
 rtl/pbit_pkg.sv | 29 ++
 rtl/synapse_accumulator_if.sv | 28 ++
 rtl/synapse_accumulator.sv | 91 +++++++++
 3 files changed

// File: rtl/pbit_pkg.sv
// Shared types and helpers for the p-bit pipeline (synapse accumulator -> p_bit).
// Latency: n/a (package only).
// Backpressure: n/a.
package pbit_pkg;

    localparam int W_WIDTH   = 4;   // signed width of each weight J_j and of the bias h
    localparam int OUT_WIDTH = 4;   // signed width of p_bit.input_val

    localparam int OUT_MAX = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Clamp a signed field value into the OUT_WIDTH signed range.
    function automatic logic signed [OUT_WIDTH-1:0] sat_to_out(input int v);
        if (v > OUT_MAX) begin
            return OUT_WIDTH'(OUT_MAX);
        end else if (v < OUT_MIN) begin
            return OUT_WIDTH'(OUT_MIN);
        end else begin
            return OUT_WIDTH'(v);
        end
    endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Bundle between the field requester (master) and the synapse accumulator (slave).
// Latency: n/a (wires only).
// Backpressure: none; start is ignored by the slave while busy is high.
// Signals: start/spins/weights/bias towards the accumulator,
//          busy/valid/input_val back from it.
interface synapse_accumulator_if
    import pbit_pkg::*;
#(
    parameter int N_NEIGH = 4
);
    logic                              start;
    logic [N_NEIGH-1:0]                spins;    // bit j = m_j (1 -> +1, 0 -> -1)
    logic [N_NEIGH*W_WIDTH-1:0]        weights;  // packed signed J_j, J_0 in the LSBs
    logic signed [W_WIDTH-1:0]         bias;
    logic                              busy;
    logic                              valid;
    logic signed [OUT_WIDTH-1:0]       input_val;

    modport master (
        output start, spins, weights, bias,
        input  busy, valid, input_val
    );

    modport slave (
        input  start, spins, weights, bias,
        output busy, valid, input_val
    );
endinterface

// File: rtl/synapse_accumulator.sv
// Local field I = h + sum_j J_j*m_j for one p-bit, one neighbour per cycle, saturated to OUT_WIDTH.
// Latency: start sampled at edge 0 -> valid/input_val after edge N_NEIGH+1; one result per N_NEIGH+2 cycles.
// Backpressure: none; start while busy is dropped (no queuing), inputs are snapshotted at start.
// Ports: clk, reset (async active-low), bus (slave modport: start/spins/weights/bias in,
//        busy/valid/input_val out).
module synapse_accumulator
    import pbit_pkg::*;
#(
    parameter int N_NEIGH   = 4,
    parameter int ACC_WIDTH = 8     // must be >= W_WIDTH + $clog2(N_NEIGH+1) + 1
)(
    input  logic                   clk,
    input  logic                   reset,
    synapse_accumulator_if.slave   bus
);

    localparam int IDX_W = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;

    state_t                          state_q;
    logic signed [ACC_WIDTH-1:0]     acc_q;
    logic signed [ACC_WIDTH-1:0]     acc_d;
    logic [IDX_W-1:0]                idx_q;
    logic [N_NEIGH-1:0]              snap_spin_q;
    logic [N_NEIGH*W_WIDTH-1:0]      snap_w_q;
    logic                            busy_q;
    logic                            valid_q;
    logic signed [OUT_WIDTH-1:0]     out_q;

    logic signed [W_WIDTH-1:0]       j_raw;
    logic signed [ACC_WIDTH-1:0]     j_ext;

    assign j_raw = snap_w_q[idx_q*W_WIDTH +: W_WIDTH];

    // Sign-extend before negating so that -(-2^(W_WIDTH-1)) is representable.
    always_comb begin
        j_ext = ACC_WIDTH'(j_raw);
        acc_d = snap_spin_q[idx_q] ? (acc_q + j_ext) : (acc_q - j_ext);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            snap_spin_q <= '0;
            snap_w_q    <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        // Neighbour spins toggle asynchronously, so work only from a snapshot.
                        snap_spin_q <= bus.spins;
                        snap_w_q    <= bus.weights;
                        acc_q       <= ACC_WIDTH'(bus.bias);
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end
                ACCUM: begin
                    valid_q <= 1'b0;
                    acc_q   <= acc_d;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(N_NEIGH - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    out_q   <= sat_to_out(int'(acc_q));
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.input_val = out_q;

endmodule
